// File: rtl/if_stage_pkg.sv
// Shared widths, constants and reset level for the instruction-fetch stage.
package if_stage_pkg;

  localparam int InstAddrW = 32;
  localparam int InstW     = 32;
  localparam int MemByteW  = 8;

  typedef logic [InstAddrW-1:0] InstAddrBus;
  typedef logic [InstW-1:0]     InstBus;
  typedef logic [MemByteW-1:0]  MemByteBus;

  localparam InstBus ZeroWord  = 32'h0000_0000;
  localparam logic   RstEnable = 1'b0;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: four byte reads per little-endian instruction,
// held for decode under stall, restarted immediately on redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    HOLD = 3'd5
  } state_e;

  state_e     state_q;
  InstAddrBus pc_q;
  logic [23:0] buf_q;
  InstAddrBus if_pc_q;
  InstBus     if_inst_q;
  logic       if_valid_q;
  logic       issue;

  // S0..S3 issue byte k = pc+k, where k is the low two bits of the state code.
  assign issue    = (state_q == S0) || (state_q == S1) || (state_q == S2) || (state_q == S3);
  assign mem_rd_o = issue && (rst != RstEnable);
  assign mem_a_o  = issue ? (pc_q + {30'b0, state_q[1:0]}) : pc_q;

  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= S0;
      pc_q       <= RESET_PC & 32'hFFFF_FFFC;
      buf_q      <= 24'h0;
      if_pc_q    <= ZeroWord;
      if_inst_q  <= ZeroWord;
      if_valid_q <= 1'b0;
    end else if (jump_en_i) begin
      // Redirect squashes any partial or held instruction; late bytes are ignored.
      state_q    <= S0;
      pc_q       <= jump_addr_i & 32'hFFFF_FFFC;
      if_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S0: state_q <= S1;
        S1: begin
          buf_q[7:0] <= mem_din_i;
          state_q    <= S2;
        end
        S2: begin
          buf_q[15:8] <= mem_din_i;
          state_q     <= S3;
        end
        S3: begin
          buf_q[23:16] <= mem_din_i;
          state_q      <= S4;
        end
        S4: begin
          if_inst_q  <= {mem_din_i, buf_q};
          if_pc_q    <= pc_q;
          if_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (!stall_i) begin
            pc_q       <= pc_q + 32'd4;
            if_valid_q <= 1'b0;
            state_q    <= S0;
          end
        end
        default: state_q <= S0;
      endcase
    end
  end

endmodule
